// File: rtl/pkt_router_ncn.sv
// Store-and-forward packet router: one input byte stream, NUM_CH per-channel FIFOs.
// Packets are written speculatively and only become visible once their XOR parity checks good.
module pkt_router_ncn #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     pkt_ok,
  output logic                     pkt_err,
  output logic [CNT_W-1:0]         ok_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_PARITY  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]        state;
  logic [CH_W-1:0]   dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] par_q;

  logic [DATA_W-1:0] mem     [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr  [NUM_CH];
  logic [AW-1:0]     cwr_ptr [NUM_CH];
  logic [AW-1:0]     swr_ptr [NUM_CH];
  logic [CW-1:0]     cnt     [NUM_CH];

  logic              xfer;
  logic [CW-1:0]     pkt_words;
  logic [CW-1:0]     free_dest;
  logic              room;
  logic              wr_hdr;
  logic              wr_pay;
  logic              par_hit;
  logic              commit;
  logic              rollback;
  logic [NUM_CH-1:0] pop;

  assign in_ready  = (state != S_WAIT);
  assign xfer      = in_valid & in_ready;
  assign pkt_words = CW'(len_q) + CW'(1);
  // Free space uses the registered count only; same-cycle pops are seen next cycle.
  assign free_dest = CW'(FIFO_DEPTH) - cnt[dest_q];
  assign room      = (free_dest >= pkt_words);
  assign wr_hdr    = (state == S_WAIT) && room;
  assign wr_pay    = (state == S_PAYLOAD) && xfer;
  assign par_hit   = (state == S_PARITY) && xfer;
  assign commit    = par_hit && ((par_q ^ in_data) == '0);
  assign rollback  = par_hit && !commit;
  assign pop       = out_valid & out_ready;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_valid[c]                    = (cnt[c] != '0);
      out_data[c*DATA_W +: DATA_W]    = mem[c][rd_ptr[c]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dest_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      ok_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      pkt_ok  <= commit;
      pkt_err <= rollback;
      if (commit)   ok_cnt   <= sat_inc(ok_cnt);
      if (rollback) drop_cnt <= sat_inc(drop_cnt);
      case (state)
        S_IDLE: if (xfer) begin
          dest_q <= in_data[CH_W-1:0];
          len_q  <= in_data[CH_W+LEN_W-1:CH_W];
          rem_q  <= in_data[CH_W+LEN_W-1:CH_W];
          state  <= S_WAIT;
        end
        S_WAIT: if (room) state <= (len_q == '0) ? S_PARITY : S_PAYLOAD;
        S_PAYLOAD: if (xfer) begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state <= S_PARITY;
        end
        default: if (xfer) state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && xfer) begin
      hdr_q <= in_data;
      par_q <= in_data;
    end else if (wr_pay) begin
      par_q <= par_q ^ in_data;
    end
    if (wr_hdr || wr_pay) mem[dest_q][swr_ptr[dest_q]] <= wr_hdr ? hdr_q : in_data;
  end

  // Pointer bookkeeping: commit publishes the speculative pointer, rollback rewinds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c]  <= '0;
        cwr_ptr[c] <= '0;
        swr_ptr[c] <= '0;
        cnt[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pop[c]) rd_ptr[c] <= next_ptr(rd_ptr[c]);
        if ((wr_hdr || wr_pay) && dest_q == CH_W'(c)) swr_ptr[c] <= next_ptr(swr_ptr[c]);
        if (commit && dest_q == CH_W'(c))   cwr_ptr[c] <= swr_ptr[c];
        if (rollback && dest_q == CH_W'(c)) swr_ptr[c] <= cwr_ptr[c];
        cnt[c] <= cnt[c] - CW'(pop[c])
                  + ((commit && dest_q == CH_W'(c)) ? pkt_words : CW'(0));
      end
    end
  end

endmodule
